// File: rtl/npu_dma_engine.sv
// Host-memory DMA engine: splits one load/store job into bursts that never cross BOUNDARY.
// Latency: load beats ack 1 cycle after mem_r handshake; store beats ack in the same cycle as the w handshake.
// Backpressure: the memory stalls through mem_a/mem_w/mem_b ready; the core cannot stall reads (mem_r_ready=1 in RD_DATA).
// Ports: clk/rstn; dma_* job interface to the NPU core; mem_a (burst request), mem_w (write beats),
//        mem_r (read beats), mem_b (write response) on a 128-bit memory bus.
module npu_dma_engine #(
   parameter int MAX_BURST = 16,
   parameter int BOUNDARY  = 4096
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         dma_req,
   output logic         dma_ready,
   input  logic         dma_rwn,
   input  logic [39:0]  dma_hostAddr,
   input  logic [15:0]  dma_tansferLength,
   input  logic [127:0] dma_writeData,
   output logic [127:0] dma_readData,
   output logic         dma_ack,
   output logic         dma_err,
   output logic         mem_a_valid,
   input  logic         mem_a_ready,
   output logic         mem_a_write,
   output logic [39:0]  mem_a_addr,
   output logic [7:0]   mem_a_beats,
   output logic         mem_w_valid,
   input  logic         mem_w_ready,
   output logic [127:0] mem_w_data,
   output logic         mem_w_last,
   input  logic         mem_r_valid,
   output logic         mem_r_ready,
   input  logic [127:0] mem_r_data,
   input  logic         mem_r_last,
   input  logic         mem_r_err,
   input  logic         mem_b_valid,
   output logic         mem_b_ready,
   input  logic         mem_b_err
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP} state_t;

   state_t        state;
   logic [39:0]   addr;
   logic [15:0]   rem;
   logic [15:0]   bcnt;
   logic          ack_rd;

   // Burst length from the latched address/remaining count. It stays constant
   // for the whole burst because addr/rem only move once the burst completes.
   logic [39:0]   off40;
   logic [39:0]   room40;
   logic [15:0]   len;

   always_comb begin
      off40  = addr & 40'(BOUNDARY - 1);
      room40 = (40'(BOUNDARY) - off40) >> 4;
      len    = rem;
      if (len > 16'(MAX_BURST))
         len = 16'(MAX_BURST);
      if (40'(len) > room40)
         len = room40[15:0];
   end

   assign dma_ready   = (state == IDLE);
   assign mem_a_valid = (state == RD_REQ) || (state == WR_REQ);
   assign mem_a_write = (state == WR_REQ);
   assign mem_a_addr  = mem_a_valid ? addr : 40'h0;
   assign mem_a_beats = mem_a_valid ? 8'(len - 16'd1) : 8'h0;
   assign mem_w_valid = (state == WR_DATA);
   assign mem_w_data  = dma_writeData;
   assign mem_w_last  = mem_w_valid && (bcnt == 16'd1);
   assign mem_r_ready = (state == RD_DATA);
   assign mem_b_ready = (state == WR_RESP);
   // Store acks are combinational so the core can advance its SRAM pointer on the handshake itself.
   assign dma_ack     = ack_rd | (mem_w_valid & mem_w_ready);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         addr         <= 40'h0;
         rem          <= 16'h0;
         bcnt         <= 16'h0;
         ack_rd       <= 1'b0;
         dma_readData <= 128'h0;
         dma_err      <= 1'b0;
      end else begin
         ack_rd <= 1'b0;
         case (state)
            IDLE: begin
               if (dma_req) begin
                  addr    <= dma_hostAddr & ~40'hF;
                  rem     <= dma_tansferLength;
                  dma_err <= 1'b0;
                  if (dma_tansferLength != 16'd0)
                     state <= dma_rwn ? RD_REQ : WR_REQ;
               end
            end
            RD_REQ: begin
               if (mem_a_ready) begin
                  bcnt  <= len;
                  state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (mem_r_valid) begin
                  dma_readData <= mem_r_data;
                  ack_rd       <= 1'b1;
                  // A misplaced last flag is flagged but ignored for counting.
                  if (mem_r_err || (mem_r_last != (bcnt == 16'd1)))
                     dma_err <= 1'b1;
                  bcnt <= bcnt - 16'd1;
                  if (bcnt == 16'd1) begin
                     addr  <= addr + (40'(len) << 4);
                     rem   <= rem - len;
                     state <= (rem == len) ? IDLE : RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (mem_a_ready) begin
                  bcnt  <= len;
                  state <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (mem_w_ready) begin
                  bcnt <= bcnt - 16'd1;
                  if (bcnt == 16'd1)
                     state <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (mem_b_valid) begin
                  if (mem_b_err)
                     dma_err <= 1'b1;
                  addr  <= addr + (40'(len) << 4);
                  rem   <= rem - len;
                  state <= (rem == len) ? IDLE : WR_REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_npu_dma_engine.sv
module tb_npu_dma_engine;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         dma_req = 1'b0;
   logic         dma_ready;
   logic         dma_rwn = 1'b0;
   logic [39:0]  dma_hostAddr = 40'h0;
   logic [15:0]  dma_tansferLength = 16'h0;
   logic [127:0] dma_writeData = 128'h0;
   logic [127:0] dma_readData;
   logic         dma_ack;
   logic         dma_err;
   logic         mem_a_valid;
   logic         mem_a_ready = 1'b0;
   logic         mem_a_write;
   logic [39:0]  mem_a_addr;
   logic [7:0]   mem_a_beats;
   logic         mem_w_valid;
   logic         mem_w_ready = 1'b0;
   logic [127:0] mem_w_data;
   logic         mem_w_last;
   logic         mem_r_valid = 1'b0;
   logic         mem_r_ready;
   logic [127:0] mem_r_data = 128'h0;
   logic         mem_r_last = 1'b0;
   logic         mem_r_err = 1'b0;
   logic         mem_b_valid = 1'b0;
   logic         mem_b_ready;
   logic         mem_b_err = 1'b0;

   npu_dma_engine #(.MAX_BURST(16), .BOUNDARY(4096)) dut (
      .clk(clk), .rstn(rstn),
      .dma_req(dma_req), .dma_ready(dma_ready), .dma_rwn(dma_rwn),
      .dma_hostAddr(dma_hostAddr), .dma_tansferLength(dma_tansferLength),
      .dma_writeData(dma_writeData), .dma_readData(dma_readData),
      .dma_ack(dma_ack), .dma_err(dma_err),
      .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_write(mem_a_write),
      .mem_a_addr(mem_a_addr), .mem_a_beats(mem_a_beats),
      .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_data(mem_w_data),
      .mem_w_last(mem_w_last),
      .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
      .mem_r_last(mem_r_last), .mem_r_err(mem_r_err),
      .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready), .mem_b_err(mem_b_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Controls written only by the stimulus block.
   logic clr = 1'b0;
   logic w_toggle = 1'b0;
   logic chk_wack = 1'b0;
   int   err_beat = -1;

   // Observations written only by the monitor.
   int           cyc = 0;
   int           n_bursts = 0, n_acks = 0, n_b = 0, n_wlast = 0, n_ackmis = 0;
   int           rd_left = 0, rbeat = 0, wbeat = 0;
   logic         b_pend = 1'b0;
   logic [39:0]  bq_addr [16];
   logic [7:0]   bq_beats [16];
   logic         bq_wr [16];
   logic [127:0] ack_dat [64];
   int           ack_cyc [64];
   logic         ack_rdy [64];
   logic         ack_err [64];
   logic [127:0] w_dat [64];
   logic         w_lst [64];

   function automatic logic [127:0] exp_rd(input int i);
      return {4{32'hA000_0000 + 32'(i)}};
   endfunction

   function automatic logic [127:0] exp_wr(input int i);
      return {4{32'hC000_0000 + 32'(i)}};
   endfunction

   // Monitor: at the falling edge everything is stable for the coming rising edge,
   // so a valid&&ready seen here is the handshake that edge will complete.
   always @(negedge clk) begin
      cyc++;
      if (clr) begin
         n_bursts = 0; n_acks = 0; n_b = 0; n_wlast = 0; n_ackmis = 0;
         rd_left = 0; rbeat = 0; wbeat = 0; b_pend = 1'b0;
      end else begin
         if (mem_a_valid && mem_a_ready) begin
            if (n_bursts < 16) begin
               bq_addr[n_bursts]  = mem_a_addr;
               bq_beats[n_bursts] = mem_a_beats;
               bq_wr[n_bursts]    = mem_a_write;
            end
            n_bursts++;
            if (!mem_a_write) rd_left = int'(mem_a_beats) + 1;
         end
         if (mem_r_valid && mem_r_ready) begin
            rd_left--;
            rbeat++;
         end
         if (mem_w_valid && mem_w_ready) begin
            if (wbeat < 64) begin
               w_dat[wbeat] = mem_w_data;
               w_lst[wbeat] = mem_w_last;
            end
            wbeat++;
            if (mem_w_last) begin
               b_pend = 1'b1;
               n_wlast++;
            end
         end
         if (mem_b_valid && mem_b_ready) begin
            n_b++;
            b_pend = 1'b0;
         end
         if (dma_ack) begin
            if (n_acks < 64) begin
               ack_dat[n_acks] = dma_readData;
               ack_cyc[n_acks] = cyc;
               ack_rdy[n_acks] = dma_ready;
               ack_err[n_acks] = dma_err;
            end
            n_acks++;
         end
         if (chk_wack && (dma_ack !== (mem_w_valid && mem_w_ready))) n_ackmis++;
      end
   end

   // Memory responder: zero-wait request channel, read beats streamed back to back.
   always @(posedge clk) begin
      #2;
      mem_a_ready   = 1'b1;
      mem_r_valid   = (rd_left > 0);
      mem_r_data    = exp_rd(rbeat);
      mem_r_last    = (rd_left == 1);
      mem_r_err     = mem_r_valid && (rbeat == err_beat);
      mem_w_ready   = w_toggle ? ~mem_w_ready : 1'b1;
      dma_writeData = exp_wr(wbeat);
      mem_b_valid   = b_pend;
      mem_b_err     = 1'b0;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      clr = 1'b1;
      @(negedge clk); #1;
      clr = 1'b0;
   endtask

   task automatic start_job(input logic rwn, input logic [39:0] a, input logic [15:0] n);
      dma_rwn = rwn;
      dma_hostAddr = a;
      dma_tansferLength = n;
      dma_req = 1'b1;
      @(posedge clk); #2;
      dma_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (dma_ready) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, done, 1'b1);
   endtask

   int notrdy;
   bit reached;

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", dma_ready, 1'b1);
      chk("rst_ack_err", {dma_ack, dma_err}, 2'b00);
      chk("rst_rdata", dma_readData, 128'h0);
      chk("rst_valids", {mem_a_valid, mem_w_valid, mem_r_ready, mem_b_ready, mem_w_last, mem_a_write}, 6'b0);
      chk("rst_a_fields", {mem_a_addr, mem_a_beats}, 48'h0);
      rstn = 1'b1;
      @(negedge clk); #1;
      clear_stats();

      // Load 0x1000 x4: single burst, acks on consecutive cycles
      start_job(1'b1, 40'h0_0000_1000, 16'd4);
      wait_idle("t1_done", 100);
      chk("t1_nbursts", n_bursts, 1);
      chk("t1_burst0", {bq_wr[0], bq_addr[0], bq_beats[0]}, {1'b0, 40'h0_0000_1000, 8'd3});
      chk("t1_nacks", n_acks, 4);
      chk("t1_dat0", ack_dat[0], 128'hA0000000_A0000000_A0000000_A0000000);
      chk("t1_dat3", ack_dat[3], 128'hA0000003_A0000003_A0000003_A0000003);
      chk("t1_consec", ack_cyc[3] - ack_cyc[0], 3);
      chk("t1_rdy_at_ack", {ack_rdy[2], ack_rdy[3]}, 2'b01);
      chk("t1_err", dma_err, 1'b0);
      clear_stats();

      // Load 0x0FE0 x5: split at the 4 KiB boundary
      start_job(1'b1, 40'h0_0000_0FE7, 16'd5);
      wait_idle("t2_done", 100);
      chk("t2_nbursts", n_bursts, 2);
      chk("t2_burst0", {bq_addr[0], bq_beats[0]}, {40'h0_0000_0FE0, 8'd1});
      chk("t2_burst1", {bq_addr[1], bq_beats[1]}, {40'h0_0000_1000, 8'd2});
      chk("t2_nacks", n_acks, 5);
      chk("t2_dat4", ack_dat[4], 128'hA0000004_A0000004_A0000004_A0000004);
      clear_stats();

      // Store 0x2000 x40 with w_ready toggling
      w_toggle = 1'b1;
      chk_wack = 1'b1;
      start_job(1'b0, 40'h0_0000_2000, 16'd40);
      wait_idle("t3_done", 400);
      chk("t3_nb_at_ready", n_b, 3);
      chk("t3_nbursts", n_bursts, 3);
      chk("t3_burst0", {bq_wr[0], bq_addr[0], bq_beats[0]}, {1'b1, 40'h0_0000_2000, 8'd15});
      chk("t3_burst1", {bq_addr[1], bq_beats[1]}, {40'h0_0000_2100, 8'd15});
      chk("t3_burst2", {bq_addr[2], bq_beats[2]}, {40'h0_0000_2200, 8'd7});
      chk("t3_nacks", n_acks, 40);
      chk("t3_nwbeats", wbeat, 40);
      chk("t3_last_pos", {w_lst[14], w_lst[15], w_lst[16], w_lst[31], w_lst[38], w_lst[39]}, 6'b010101);
      chk("t3_nlast", n_wlast, 3);
      chk("t3_ack_hs", n_ackmis, 0);
      chk("t3_wdat0", w_dat[0], 128'hC0000000_C0000000_C0000000_C0000000);
      chk("t3_wdat39", w_dat[39], 128'hC0000027_C0000027_C0000027_C0000027);
      w_toggle = 1'b0;
      chk_wack = 1'b0;
      clear_stats();

      // Load x8 with a read error on beat 3
      err_beat = 2;
      start_job(1'b1, 40'h0_0000_5000, 16'd8);
      wait_idle("t5_done", 100);
      chk("t5_nacks", n_acks, 8);
      chk("t5_err_by_ack", {ack_err[1], ack_err[2], ack_err[7]}, 3'b011);
      chk("t5_dat7", ack_dat[7], 128'hA0000007_A0000007_A0000007_A0000007);
      repeat (3) @(negedge clk);
      #1;
      chk("t5_err_sticky", dma_err, 1'b1);
      err_beat = -1;
      clear_stats();

      // Length 0 at 0x3000: accepted, clears the error, nothing else happens
      start_job(1'b1, 40'h0_0000_3000, 16'd0);
      notrdy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (!dma_ready) notrdy++;
      end
      chk("t4_ready_held", notrdy, 0);
      chk("t4_nbursts", n_bursts, 0);
      chk("t4_nacks", n_acks, 0);
      chk("t4_err_cleared", dma_err, 1'b0);
      clear_stats();

      // Reset during WR_DATA after 2 of 16 beats
      start_job(1'b0, 40'h0_0000_4000, 16'd16);
      reached = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (wbeat >= 2) begin
            reached = 1'b1;
            break;
         end
      end
      chk("t6_two_beats", reached, 1'b1);
      @(posedge clk); #3;
      rstn = 1'b0;
      #1;
      chk("t6_rst_ready", dma_ready, 1'b1);
      chk("t6_rst_ack_err", {dma_ack, dma_err}, 2'b00);
      chk("t6_rst_rdata", dma_readData, 128'h0);
      chk("t6_rst_valids", {mem_a_valid, mem_w_valid, mem_w_last, mem_r_ready, mem_b_ready}, 5'b0);
      chk("t6_rst_a_fields", {mem_a_addr, mem_a_beats, mem_a_write}, 49'h0);
      @(negedge clk); #1;
      rstn = 1'b1;
      clear_stats();
      start_job(1'b1, 40'h0_0000_6000, 16'd1);
      wait_idle("t6_load_done", 100);
      chk("t6_nbursts", n_bursts, 1);
      chk("t6_burst0", {bq_wr[0], bq_addr[0], bq_beats[0]}, {1'b0, 40'h0_0000_6000, 8'd0});
      chk("t6_nacks", n_acks, 1);
      chk("t6_dat0", ack_dat[0], 128'hA0000000_A0000000_A0000000_A0000000);
      chk("t6_err", dma_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/npu_dma_engine.md
Name: npu_dma_engine

Overview:
- Host-memory DMA engine directly downstream of the NPU core's dma_* port.
- Accepts one job at a time: load (host to core) or store (core to host), length counted in 128-bit beats.
- Splits each job into bursts on a 128-bit memory bus with split request, write-data, read-data and write-response channels.
- The NPU core writes SRAM itself on each dma_ack, so this engine never touches SRAM.

Parameters:
- MAX_BURST, 16, maximum beats per memory burst (power of 2, 1..256).
- BOUNDARY, 4096, bytes; no burst crosses a multiple of BOUNDARY (power of 2, >= 16*MAX_BURST).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- dma_req  in  1  job request; held high by the core until dma_ready is seen.
- dma_ready  out  1  engine idle; a job is accepted on the cycle dma_req && dma_ready.
- dma_rwn  in  1  1 = load (host read), 0 = store (host write).
- dma_hostAddr  in  40  host byte address; bits [3:0] are ignored (forced to 0).
- dma_tansferLength  in  16  job length in 128-bit beats.
- dma_writeData  in  128  store data; valid while the store job is active.
- dma_readData  out  128  load data; valid when dma_ack=1.
- dma_ack  out  1  one pulse per beat transferred.
- dma_err  out  1  sticky error flag for the current or last job.
- mem_a_valid / mem_a_ready  out/in  1/1  burst request handshake.
- mem_a_write  out  1  1 = write burst.
- mem_a_addr  out  40  burst start address, 16-byte aligned.
- mem_a_beats  out  8  beats in the burst minus 1.
- mem_w_valid / mem_w_ready  out/in  1/1  write-beat handshake.
- mem_w_data  out  128  write beat.
- mem_w_last  out  1  last beat of the burst.
- mem_r_valid  in  1  read beat valid.
- mem_r_ready  out  1  read beat ready.
- mem_r_data  in  128  read beat data.
- mem_r_last  in  1  last read beat of the burst.
- mem_r_err  in  1  read beat error.
- mem_b_valid  in  1  write response valid.
- mem_b_ready  out  1  write response ready.
- mem_b_err  in  1  write response error.

Behaviour:
- Reset values: dma_ready=1; dma_ack=0; dma_readData=0; dma_err=0; all mem_*_valid=0; mem_r_ready=0; mem_b_ready=0; mem_a_* and mem_w_last=0; state=IDLE.
- Reset asserted mid-job aborts immediately. Outstanding bus beats are not drained; the bus fabric is reset by the same rstn.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP.
- IDLE, on accept:
  - Latch addr={hostAddr[39:4],4'h0}, rem=tansferLength, rwn.
  - Clear dma_err; dma_ready=0 from the next cycle.
  - If tansferLength==0: stay IDLE with dma_ready held high; no ack, no bus activity.
  - Otherwise go to RD_REQ or WR_REQ.
- Burst sizing:
  - len = min(rem, MAX_BURST, (BOUNDARY - addr%BOUNDARY)/16).
  - Computed combinationally from the latched addr/rem.
  - mem_a_beats = len-1.
- RD_REQ / WR_REQ:
  - mem_a_valid=1 with stable addr, beats and write; held until mem_a_ready.
  - On handshake go to RD_DATA / WR_DATA; bcnt=len.
- RD_DATA:
  - mem_r_ready=1 always (the core cannot backpressure).
  - Each r handshake registers dma_readData<=mem_r_data and pulses dma_ack the next cycle. Read latency is 1 cycle; back-to-back acks are allowed.
  - mem_r_err sets dma_err.
  - On the beat with bcnt==1: addr+=16*len, rem-=len. If rem becomes 0, go to IDLE with dma_ready=1 in the same cycle as the final dma_ack. Otherwise go to RD_REQ.
  - mem_r_last mismatching bcnt==1 sets dma_err; counting stays on bcnt.
- WR_DATA:
  - mem_w_valid=1; mem_w_data=dma_writeData (combinational pass-through); mem_w_last=(bcnt==1).
  - dma_ack = mem_w_valid && mem_w_ready, combinational, same cycle. The core presents the next beat by the following cycle.
  - After the last beat of the burst go to WR_RESP.
- WR_RESP:
  - mem_b_ready=1; mem_b_err sets dma_err.
  - On b handshake update addr/rem. rem==0 goes to IDLE; otherwise go to WR_REQ.
  - dma_ready rises only after the final write response.
- Ordering and width:
  - One burst outstanding at a time.
  - rem and bcnt are 16-bit; addr arithmetic is 40-bit and wraps at 2^40 without error.
- dma_req seen while dma_ready=0 is ignored; job fields are sampled only at accept.
- dma_err stays high after the job ends until the next accept.

Test Plan:
- Load, addr 0x1000, length 4, MAX_BURST 16, zero-wait memory -> one burst (addr 0x1000, beats=3); 4 acks on consecutive cycles with data matching the r beats in order; dma_ready high on the cycle of the 4th ack.
- Load, addr 0x0FE0, length 5 -> bursts (0x0FE0, beats=1) then (0x1000, beats=2); 5 acks total; no burst crosses 0x1000.
- Store, addr 0x2000, length 40, mem_w_ready toggling every cycle ->
  - Bursts of 16, 16, 8 beats.
  - mem_w_last on beats 16, 32, 40.
  - Exactly 40 acks, each coincident with a w handshake.
  - dma_ready rises only after the 3rd b handshake.
- Length 0 with addr 0x3000 -> no mem_a_valid, no dma_ack; dma_ready stays 1.
- Load of 8 beats with mem_r_err on beat 3 -> all 8 acks still delivered; dma_err=1 from the cycle after beat 3 until the next accepted request, which clears it.
- rstn pulsed low during WR_DATA after 2 of 16 beats -> all outputs immediately take their reset values; a subsequent load of length 1 completes normally.
